// File: rtl/sat_trunc_fp.sv
// Registered requantizer: S(NB_XI,NBF_XI) -> S(NB_XO,NBF_XO), truncate or round-half-up, then clamp.
// Latency 1 clock; i_en gates the output register (hold when low), no backpressure.
module sat_trunc_fp #(
    parameter int NB_XI  = 20,
    parameter int NBF_XI = 12,
    parameter int NB_XO  = 8,
    parameter int NBF_XO = 7,
    parameter bit ROUND  = 1'b0
) (
    input  logic             clk,
    input  logic             i_rst_n,
    input  logic             i_en,
    input  logic [NB_XI-1:0] i_data,
    output logic [NB_XO-1:0] o_data,
    output logic             o_sat
);

    localparam int D  = NBF_XI - NBF_XO;
    localparam int RS = (D > 0) ? D - 1 : 0;
    localparam logic [NB_XI:0] ONE = {{NB_XI{1'b0}}, 1'b1};
    localparam logic [NB_XI:0] RC  = (ROUND && (D > 0)) ? (ONE << RS) : '0;
    localparam logic [NB_XO-1:0] OUT_MAX = {1'b0, {(NB_XO-1){1'b1}}};
    localparam logic [NB_XO-1:0] OUT_MIN = {1'b1, {(NB_XO-1){1'b0}}};

    logic signed [NB_XI:0]         ext;
    logic signed [NB_XI:0]         sum;
    logic signed [NB_XI:0]         t;
    logic [NB_XI-NB_XO+1:0]        hi;
    logic                          ovf;
    logic [NB_XO-1:0]              nxt_data;

    // One guard bit above the input keeps the rounding add from wrapping at +full-scale.
    always_comb begin
        ext = $signed({i_data[NB_XI-1], i_data});
        sum = ext + $signed(RC);
        t   = sum >>> D;
        hi  = t[NB_XI:NB_XO-1];
        ovf = ~((&hi) | (~|hi));
        nxt_data = t[NB_XO-1:0];
        if (ovf) begin
            nxt_data = t[NB_XI] ? OUT_MIN : OUT_MAX;
        end
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_data <= '0;
            o_sat  <= 1'b0;
        end else if (i_en) begin
            o_data <= nxt_data;
            o_sat  <= ovf;
        end
    end

endmodule

// File: tb/tb_sat_trunc_fp.sv
// Directed bench for sat_trunc_fp: one truncating and one rounding instance share the same stimulus.
module tb_sat_trunc_fp;

    logic        clk = 1'b0;
    logic        i_rst_n;
    logic        i_en;
    logic [19:0] i_data;
    logic [7:0]  o_data_t, o_data_r;
    logic        o_sat_t, o_sat_r;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    sat_trunc_fp #(.NB_XI(20), .NBF_XI(12), .NB_XO(8), .NBF_XO(7), .ROUND(1'b0)) u_trunc (
        .clk(clk), .i_rst_n(i_rst_n), .i_en(i_en), .i_data(i_data),
        .o_data(o_data_t), .o_sat(o_sat_t)
    );

    sat_trunc_fp #(.NB_XI(20), .NBF_XI(12), .NB_XO(8), .NBF_XO(7), .ROUND(1'b1)) u_round (
        .clk(clk), .i_rst_n(i_rst_n), .i_en(i_en), .i_data(i_data),
        .o_data(o_data_r), .o_sat(o_sat_r)
    );

    // Integer reference: floor-divide by 32 (after +16 when rounding), clamp to [-128,127].
    function automatic logic [8:0] ref_q(input logic [19:0] d, input bit rnd);
        int v;
        int q;
        v = int'(signed'({{12{d[19]}}, d}));
        if (rnd) v = v + 16;
        q = v >>> 5;
        if (q > 127)       return {1'b1, 8'h7F};
        else if (q < -128) return {1'b1, 8'h80};
        else               return {1'b0, q[7:0]};
    endfunction

    task automatic test_reset();
        i_rst_n = 1'b0;
        i_en    = 1'b1;
        i_data  = 20'h00800;
        #1;
        n_cmp++;
        if ({o_sat_t, o_data_t} !== 9'h000) begin
            n_fail++;
            $display("FAIL reset_initial: got sat=%0b data=%02h, want sat=0 data=00", o_sat_t, o_data_t);
        end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            i_data = (i % 2 == 0) ? 20'h00000 : 20'h00800;
            n_cmp++;
            if ({o_sat_t, o_data_t, o_sat_r, o_data_r} !== 18'h0) begin
                n_fail++;
                $display("FAIL reset_hold: got t=%02h/%0b r=%02h/%0b, want 00/0", o_data_t, o_sat_t, o_data_r, o_sat_r);
            end
        end
        @(negedge clk);
        i_rst_n = 1'b1;
        i_data  = 20'h00800;
        @(posedge clk);
        #1;
        n_cmp++;
        if ({o_sat_t, o_data_t} !== {1'b0, 8'h40}) begin
            n_fail++;
            $display("FAIL reset_release_load: got sat=%0b data=%02h, want sat=0 data=40", o_sat_t, o_data_t);
        end
        // Mid-stream async reset, asserted well away from any clock edge.
        #2;
        i_rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({o_sat_t, o_data_t} !== 9'h000) begin
            n_fail++;
            $display("FAIL reset_async_mid: got sat=%0b data=%02h, want sat=0 data=00", o_sat_t, o_data_t);
        end
        @(negedge clk);
        i_rst_n = 1'b1;
    endtask

    task automatic test_trunc();
        logic [19:0] vin [8] = '{20'h00800, 20'hFF000, 20'h0081F, 20'hFFFFF,
                                 20'h01000, 20'h7FFFF, 20'hFE000, 20'h80000};
        logic [8:0]  vexp [8] = '{9'h040, 9'h080, 9'h040, 9'h0FF,
                                  9'h17F, 9'h17F, 9'h180, 9'h180};
        i_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            i_data = vin[i];
            @(posedge clk);
            #1;
            n_cmp++;
            if ({o_sat_t, o_data_t} !== vexp[i]) begin
                n_fail++;
                $display("FAIL trunc[%05h]: got sat=%0b data=%02h, want sat=%0b data=%02h",
                         vin[i], o_sat_t, o_data_t, vexp[i][8], vexp[i][7:0]);
            end
        end
    endtask

    task automatic test_round();
        logic [19:0] vin [7] = '{20'h0081F, 20'h00810, 20'h0080F, 20'hFFFFF,
                                 20'h00FF0, 20'h7FFFF, 20'h80000};
        logic [8:0]  vexp [7] = '{9'h041, 9'h041, 9'h040, 9'h000,
                                  9'h17F, 9'h17F, 9'h180};
        i_en = 1'b1;
        for (int i = 0; i < 7; i++) begin
            i_data = vin[i];
            @(posedge clk);
            #1;
            n_cmp++;
            if ({o_sat_r, o_data_r} !== vexp[i]) begin
                n_fail++;
                $display("FAIL round[%05h]: got sat=%0b data=%02h, want sat=%0b data=%02h",
                         vin[i], o_sat_r, o_data_r, vexp[i][8], vexp[i][7:0]);
            end
        end
        // Truncating path must not round the same +127.5 value up into saturation.
        i_data = 20'h00FF0;
        @(posedge clk);
        #1;
        n_cmp++;
        if ({o_sat_t, o_data_t} !== 9'h07F) begin
            n_fail++;
            $display("FAIL trunc_no_round[00ff0]: got sat=%0b data=%02h, want sat=0 data=7f", o_sat_t, o_data_t);
        end
    endtask

    task automatic test_enable_hold();
        i_en   = 1'b1;
        i_data = 20'h00800;
        @(posedge clk);
        #1;
        n_cmp++;
        if ({o_sat_t, o_data_t} !== 9'h040) begin
            n_fail++;
            $display("FAIL en_load: got sat=%0b data=%02h, want sat=0 data=40", o_sat_t, o_data_t);
        end
        i_en   = 1'b0;
        i_data = 20'h01000;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            n_cmp++;
            if ({o_sat_t, o_data_t} !== 9'h040) begin
                n_fail++;
                $display("FAIL en_hold[%0d]: got sat=%0b data=%02h, want sat=0 data=40", i, o_sat_t, o_data_t);
            end
        end
        i_en = 1'b1;
        @(posedge clk);
        #1;
        n_cmp++;
        if ({o_sat_t, o_data_t} !== 9'h17F) begin
            n_fail++;
            $display("FAIL en_resume: got sat=%0b data=%02h, want sat=1 data=7f", o_sat_t, o_data_t);
        end
    endtask

    task automatic test_back_to_back();
        logic [19:0] w;
        logic [8:0]  et, er;
        i_en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            if (i % 2 == 0) w = 20'($urandom);
            else            w = 20'($signed($urandom_range(0, 8191)) - 4096);
            i_data = w;
            et = ref_q(w, 1'b0);
            er = ref_q(w, 1'b1);
            @(posedge clk);
            #1;
            n_cmp++;
            if ({o_sat_t, o_data_t, o_sat_r, o_data_r} !== {et, er}) begin
                n_fail++;
                $display("FAIL stream[%0d] in=%05h: got t=%02h/%0b r=%02h/%0b, want t=%02h/%0b r=%02h/%0b",
                         i, w, o_data_t, o_sat_t, o_data_r, o_sat_r, et[7:0], et[8], er[7:0], er[8]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_trunc();
        test_round();
        test_enable_hold();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
